replacement_access_driver: RTL and testbench
============================================

# replacement_access_driver

Master-side driver for the cache unit's replacement-algorithm interface in the invalidate-protocol snoopy cache. It tracks per-line valid bits and serves line-allocation requests from the cache controller. On each request it picks a victim, evicts it through a handshake if needed, and grants the line. It forwards hit and snoop-invalidate events to the replacement algorithm as single-cycle access/invalidate pulses.

## Interface
Parameters:
- NUMBER_OF_CACHE_LINES, 8, lines in the cache (2..256)
- COUNTER_WIDTH, ceil(log2(NUMBER_OF_CACHE_LINES)), minimum 1, line-index width

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low
- hitEnable  input  1  CPU hit this cycle
- hitCacheLine  input  COUNTER_WIDTH  line that hit
- snoopInvalidateEnable  input  1  bus snoop invalidates a line
- snoopInvalidateLine  input  COUNTER_WIDTH  line invalidated by snoop
- allocateRequest  input  1  miss; a line is needed; held until grant
- allocateGrant  output  1  one-cycle pulse; allocation complete
- allocatedCacheLine  output  COUNTER_WIDTH  granted line, valid with allocateGrant
- evictRequest  output  1  victim write-back/flush request; held until evictDone
- evictCacheLine  output  COUNTER_WIDTH  line to evict
- evictDone  input  1  eviction finished
- lastAccessedCacheLine  output  COUNTER_WIDTH  to replacement algorithm
- accessEnable  output  1  to replacement algorithm
- invalidatedCacheLine  output  COUNTER_WIDTH  to replacement algorithm
- invalidateEnable  output  1  to replacement algorithm
- replacementCacheLine  input  COUNTER_WIDTH  victim proposed by replacement algorithm

## Operation
- Valid vector `valid[NUMBER_OF_CACHE_LINES]`. All lines are cleared by reset.
- FSM states are IDLE, SELECT, EVICT and GRANT. The FSM resets to IDLE.
- IDLE: if allocateRequest is high, go to SELECT.
- SELECT: register the victim.
  - If the victim is valid, go to EVICT.
  - If the victim is invalid, go to GRANT.
- EVICT:
  - evictRequest is high and evictCacheLine holds the victim.
  - When evictDone is high, clear valid[victim] and go to GRANT.
- GRANT:
  - Drive allocateGrant=1, allocatedCacheLine=victim, accessEnable=1 and lastAccessedCacheLine=victim.
  - Set valid[victim].
  - Go to IDLE.
- Hit handling: a hit is honoured only in IDLE. The next cycle drives accessEnable=1 and lastAccessedCacheLine=hitCacheLine.
  - hitEnable outside IDLE is ignored, because the CPU is stalled during a miss.
- Snoop handling: a snoop is honoured in every state. It clears valid[line]. The next cycle drives invalidateEnable=1 and invalidatedCacheLine=line.
- Snoop during EVICT on the victim: the eviction still waits for evictDone. The line ends up invalid, then the grant proceeds.
- Snoop and GRANT on the same line in the same cycle: the grant's valid-set wins, because the new contents belong to a different tag. The invalidateEnable pulse is still emitted.
- allocateRequest dropped before grant is illegal; the controller never does this.
- allocateRequest still high in the cycle after the grant starts a new allocation.
- evictDone outside EVICT is ignored.

## Timing
- All outputs are registered.
- Reset values of all outputs are 0: allocateGrant, allocatedCacheLine, evictRequest, evictCacheLine, accessEnable, lastAccessedCacheLine, invalidateEnable, invalidatedCacheLine.
- Request sampled at edge 0 with no eviction: SELECT at edge 1, allocateGrant high in the cycle after edge 2. This is 2-cycle latency.
- With eviction: evictRequest rises after edge 2. allocateGrant follows one cycle after evictDone is sampled.
- Hit and snoop pulses come out exactly one cycle after the input and last exactly one cycle.
- The replacement algorithm's replacementCacheLine is sampled only in SELECT.
- An asynchronous reset mid-operation forces IDLE at once:
  - all valid bits clear;
  - evictRequest drops;
  - any pending pulses are lost.

## Configuration
- `REPLACEMENT_PREFER_INVALID_EN` defined:
  - In SELECT, the lowest-index invalid line is chosen if one exists.
  - replacementCacheLine is used only when all lines are valid.
  - Eviction therefore happens only when the cache is full.
- Undefined:
  - The victim is always replacementCacheLine.
  - If that line is invalid, there is no eviction.

## Structure
- Package `replacement_pkg` holds:
  - the FSM state enum `replacement_state_t`;
  - a width helper function `counter_width(lines)`, used for COUNTER_WIDTH.
- Sub-module `invalid_line_finder` is a parameterised priority encoder. It takes the valid vector and produces {found, lowest invalid index}. It is instantiated only under `REPLACEMENT_PREFER_INVALID_EN`.

## Test plan
- Cold allocation with the macro on, after reset, N=8: request. Expect allocatedCacheLine=0 two cycles later, accessEnable pulse with lastAccessedCacheLine=0, and no evictRequest.
- Full cache with the macro on: allocate 8 times, then request with replacementCacheLine=5. Expect evictRequest with evictCacheLine=5. Assert evictDone 3 cycles later and expect allocateGrant with line 5 on the next cycle.
- Macro off: request with replacementCacheLine=3 while line 3 is invalid. Expect grant of line 3 with no eviction.
- Hit with snoop in IDLE: hitEnable on line 2 and snoopInvalidateEnable on line 6 together. Next cycle expect accessEnable with line 2 and invalidateEnable with line 6.
- Snoop on the victim during EVICT (line 5): expect the eviction to hold until evictDone, the grant of line 5, and valid[5]=1 at the end.
- Reset asserted during EVICT: expect evictRequest=0 immediately and all outputs 0. After release, the first allocation returns line 0 with the macro on.

Source files
------------

// File: rtl/replacement_pkg.sv
// Shared types and helpers for the replacement access driver.
// Optional feature macro: REPLACEMENT_PREFER_INVALID_EN (see replacement_access_driver.sv).
package replacement_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    EVICT  = 2'd2,
    GRANT  = 2'd3
  } replacement_state_t;

  // Line-index width: ceil(log2(lines)), never below 1.
  function automatic int counter_width(input int lines);
    int w;
    w = 1;
    while ((1 << w) < lines) w++;
    return w;
  endfunction

endpackage

// File: rtl/invalid_line_finder.sv
// Priority encoder over the valid vector: reports whether any line is
// invalid and the lowest such index.
module invalid_line_finder #(
  parameter int NUMBER_OF_CACHE_LINES = 8,
  parameter int COUNTER_WIDTH         = 3
) (
  input  logic [NUMBER_OF_CACHE_LINES-1:0] valid,
  output logic                             found,
  output logic [COUNTER_WIDTH-1:0]         lowestInvalid
);

  // Scan from the top down so the lowest invalid index is the last write.
  always_comb begin
    found         = 1'b0;
    lowestInvalid = '0;
    for (int i = NUMBER_OF_CACHE_LINES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        found         = 1'b1;
        lowestInvalid = COUNTER_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/replacement_access_driver.sv
// Master-side driver for the replacement-algorithm interface: tracks line
// valid bits, serves allocations (select victim, optional eviction, grant)
// and forwards hit/snoop events as one-cycle access/invalidate pulses.
// Build option: define REPLACEMENT_PREFER_INVALID_EN to pick the lowest
// invalid line before consulting the replacement algorithm.
module replacement_access_driver
  import replacement_pkg::*;
#(
  parameter int NUMBER_OF_CACHE_LINES = 8,
  parameter int COUNTER_WIDTH         = counter_width(NUMBER_OF_CACHE_LINES)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     hitEnable,
  input  logic [COUNTER_WIDTH-1:0] hitCacheLine,
  input  logic                     snoopInvalidateEnable,
  input  logic [COUNTER_WIDTH-1:0] snoopInvalidateLine,
  input  logic                     allocateRequest,
  output logic                     allocateGrant,
  output logic [COUNTER_WIDTH-1:0] allocatedCacheLine,
  output logic                     evictRequest,
  output logic [COUNTER_WIDTH-1:0] evictCacheLine,
  input  logic                     evictDone,
  output logic [COUNTER_WIDTH-1:0] lastAccessedCacheLine,
  output logic                     accessEnable,
  output logic [COUNTER_WIDTH-1:0] invalidatedCacheLine,
  output logic                     invalidateEnable,
  input  logic [COUNTER_WIDTH-1:0] replacementCacheLine
);

  replacement_state_t               state, nextState;
  logic [NUMBER_OF_CACHE_LINES-1:0] valid;
  logic [COUNTER_WIDTH-1:0]         victim, victimNext;
  logic                             victimNextValid;
  logic                             evictAck;

  // evictDone only counts once the request is actually visible outside.
  assign evictAck = evictRequest && evictDone;

`ifdef REPLACEMENT_PREFER_INVALID_EN
  logic                     invalidFound;
  logic [COUNTER_WIDTH-1:0] firstInvalid;

  invalid_line_finder #(
    .NUMBER_OF_CACHE_LINES(NUMBER_OF_CACHE_LINES),
    .COUNTER_WIDTH        (COUNTER_WIDTH)
  ) finder (
    .valid        (valid),
    .found        (invalidFound),
    .lowestInvalid(firstInvalid)
  );

  assign victimNext = invalidFound ? firstInvalid : replacementCacheLine;
`else
  assign victimNext = replacementCacheLine;
`endif

  // Valid bit of the proposed victim; out-of-range indices read as invalid.
  always_comb begin
    victimNextValid = 1'b0;
    for (int i = 0; i < NUMBER_OF_CACHE_LINES; i++) begin
      if (victimNext == COUNTER_WIDTH'(i)) victimNextValid = valid[i];
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // FSM next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (allocateRequest) nextState = SELECT;
      SELECT:  nextState = victimNextValid ? EVICT : GRANT;
      EVICT:   if (evictAck) nextState = GRANT;
      GRANT:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Victim is captured once, in SELECT, and held through EVICT/GRANT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)               victim <= '0;
    else if (state == SELECT) victim <= victimNext;
  end

  // Valid bits: snoop clear, eviction clear, then grant set (grant wins,
  // since the newly allocated contents belong to a different tag).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < NUMBER_OF_CACHE_LINES; i++) begin
        if (snoopInvalidateEnable && snoopInvalidateLine == COUNTER_WIDTH'(i))
          valid[i] <= 1'b0;
        if (state == EVICT && evictAck && victim == COUNTER_WIDTH'(i))
          valid[i] <= 1'b0;
        if (state == GRANT && victim == COUNTER_WIDTH'(i))
          valid[i] <= 1'b1;
      end
    end
  end

  // Registered interface outputs; pulses last exactly one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      allocateGrant         <= 1'b0;
      allocatedCacheLine    <= '0;
      evictRequest          <= 1'b0;
      evictCacheLine        <= '0;
      accessEnable          <= 1'b0;
      lastAccessedCacheLine <= '0;
      invalidateEnable      <= 1'b0;
      invalidatedCacheLine  <= '0;
    end else begin
      allocateGrant <= (state == GRANT);
      if (state == GRANT) allocatedCacheLine <= victim;

      evictRequest <= (state == EVICT) && !evictAck;
      if (state == EVICT) evictCacheLine <= victim;

      // Hits are only honoured in IDLE; the CPU is stalled during a miss.
      accessEnable <= (state == GRANT) || (state == IDLE && hitEnable);
      if (state == GRANT)                  lastAccessedCacheLine <= victim;
      else if (state == IDLE && hitEnable) lastAccessedCacheLine <= hitCacheLine;

      invalidateEnable <= snoopInvalidateEnable;
      if (snoopInvalidateEnable) invalidatedCacheLine <= snoopInvalidateLine;
    end
  end

endmodule

// File: tb/tb_replacement_access_driver.sv
// Directed bench for replacement_access_driver (8 lines), both build variants.
module tb_replacement_access_driver;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       hitEnable = 1'b0;
  logic [2:0] hitCacheLine = '0;
  logic       snoopInvalidateEnable = 1'b0;
  logic [2:0] snoopInvalidateLine = '0;
  logic       allocateRequest = 1'b0;
  logic       allocateGrant;
  logic [2:0] allocatedCacheLine;
  logic       evictRequest;
  logic [2:0] evictCacheLine;
  logic       evictDone = 1'b0;
  logic [2:0] lastAccessedCacheLine;
  logic       accessEnable;
  logic [2:0] invalidatedCacheLine;
  logic       invalidateEnable;
  logic [2:0] replacementCacheLine = '0;

  int checks = 0;
  int errors = 0;
  bit validM [8];

  replacement_access_driver #(.NUMBER_OF_CACHE_LINES(8)) dut (
    .clock                (clock),
    .reset                (reset),
    .hitEnable            (hitEnable),
    .hitCacheLine         (hitCacheLine),
    .snoopInvalidateEnable(snoopInvalidateEnable),
    .snoopInvalidateLine  (snoopInvalidateLine),
    .allocateRequest      (allocateRequest),
    .allocateGrant        (allocateGrant),
    .allocatedCacheLine   (allocatedCacheLine),
    .evictRequest         (evictRequest),
    .evictCacheLine       (evictCacheLine),
    .evictDone            (evictDone),
    .lastAccessedCacheLine(lastAccessedCacheLine),
    .accessEnable         (accessEnable),
    .invalidatedCacheLine (invalidatedCacheLine),
    .invalidateEnable     (invalidateEnable),
    .replacementCacheLine (replacementCacheLine)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       hitEn;
    logic [2:0] hitLine;
    logic       snpEn;
    logic [2:0] snpLine;
    logic       expAcc;
    logic [2:0] expAccLine;
    logic       expInv;
    logic [2:0] expInvLine;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, ".allocateGrant"}, allocateGrant, 0);
    chk({tag, ".allocatedCacheLine"}, allocatedCacheLine, 0);
    chk({tag, ".evictRequest"}, evictRequest, 0);
    chk({tag, ".evictCacheLine"}, evictCacheLine, 0);
    chk({tag, ".accessEnable"}, accessEnable, 0);
    chk({tag, ".lastAccessedCacheLine"}, lastAccessedCacheLine, 0);
    chk({tag, ".invalidateEnable"}, invalidateEnable, 0);
    chk({tag, ".invalidatedCacheLine"}, invalidatedCacheLine, 0);
  endtask

  // Expected victim from the bench's own view of line validity.
  function automatic logic [2:0] expVictim(input logic [2:0] repl);
    logic [2:0] v;
    v = repl;
`ifdef REPLACEMENT_PREFER_INVALID_EN
    for (int i = 7; i >= 0; i--) if (!validM[i]) v = 3'(i);
`endif
    return v;
  endfunction

  // Full allocation; snp snoops the victim during GRANT (no eviction) or
  // during the first EVICT wait cycle. Hits are driven while evicting.
  task automatic alloc(input logic [2:0] repl, input bit snp);
    logic [2:0] v;
    bit ev;
    v  = expVictim(repl);
    ev = validM[v];
    @(negedge clock);
    allocateRequest      = 1'b1;
    replacementCacheLine = repl;
    @(negedge clock);
    @(negedge clock);
    chk("grantLatency", allocateGrant, 0);
    if (!ev) begin
      if (snp) begin
        snoopInvalidateEnable = 1'b1;
        snoopInvalidateLine   = v;
        validM[v]             = 1'b0;
      end
      @(negedge clock);
      snoopInvalidateEnable = 1'b0;
      chk("grant", allocateGrant, 1);
      chk("grantLine", allocatedCacheLine, v);
      chk("grantAccess", accessEnable, 1);
      chk("grantAccessLine", lastAccessedCacheLine, v);
      chk("noEvict", evictRequest, 0);
      if (snp) begin
        chk("grantSnoopInv", invalidateEnable, 1);
        chk("grantSnoopLine", invalidatedCacheLine, v);
      end
    end else begin
      @(negedge clock);
      chk("evictReq", evictRequest, 1);
      chk("evictLine", evictCacheLine, v);
      chk("evictNoGrant", allocateGrant, 0);
      hitEnable    = 1'b1;
      hitCacheLine = v + 3'd1;
      for (int i = 0; i < 3; i++) begin
        if (snp && i == 0) begin
          snoopInvalidateEnable = 1'b1;
          snoopInvalidateLine   = v;
          validM[v]             = 1'b0;
        end
        @(negedge clock);
        snoopInvalidateEnable = 1'b0;
        chk("evictHold", evictRequest, 1);
        chk("hitIgnored", accessEnable, 0);
        if (snp && i == 0) begin
          chk("evictSnoopInv", invalidateEnable, 1);
          chk("evictSnoopLine", invalidatedCacheLine, v);
        end
      end
      hitEnable = 1'b0;
      evictDone = 1'b1;
      @(negedge clock);
      evictDone = 1'b0;
      chk("evictDrop", evictRequest, 0);
      chk("grantNotYet", allocateGrant, 0);
      @(negedge clock);
      chk("evGrant", allocateGrant, 1);
      chk("evGrantLine", allocatedCacheLine, v);
      chk("evGrantAccess", accessEnable, 1);
      chk("evGrantAccessLine", lastAccessedCacheLine, v);
    end
    allocateRequest = 1'b0;
    validM[v]       = 1'b1;
    @(negedge clock);
    chk("grantPulse", allocateGrant, 0);
    chk("accessPulse", accessEnable, 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'd2, 1'b1, 3'd6, 1'b1, 3'd2, 1'b1, 3'd6};
    vecs[1] = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 3'd6};
    vecs[2] = '{1'b1, 3'd7, 1'b0, 3'd0, 1'b1, 3'd7, 1'b0, 3'd6};
    vecs[3] = '{1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 3'd7, 1'b1, 3'd0};
    vecs[4] = '{1'b1, 3'd0, 1'b1, 3'd7, 1'b1, 3'd0, 1'b1, 3'd7};
    vecs[5] = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7};
    for (int i = 0; i < 8; i++) validM[i] = 1'b0;

    repeat (2) @(negedge clock);
    checkAllZero("reset");
    reset = 1'b1;

    // Hit/snoop pulses in IDLE.
    foreach (vecs[i]) begin
      @(negedge clock);
      hitEnable             = vecs[i].hitEn;
      hitCacheLine          = vecs[i].hitLine;
      snoopInvalidateEnable = vecs[i].snpEn;
      snoopInvalidateLine   = vecs[i].snpLine;
      if (vecs[i].snpEn) validM[vecs[i].snpLine] = 1'b0;
      @(negedge clock);
      hitEnable             = 1'b0;
      snoopInvalidateEnable = 1'b0;
      chk($sformatf("vec%0d.accessEnable", i), accessEnable, vecs[i].expAcc);
      if (vecs[i].expAcc) chk($sformatf("vec%0d.lastAccessed", i), lastAccessedCacheLine, vecs[i].expAccLine);
      chk($sformatf("vec%0d.invalidateEnable", i), invalidateEnable, vecs[i].expInv);
      if (vecs[i].expInv) chk($sformatf("vec%0d.invalidated", i), invalidatedCacheLine, vecs[i].expInvLine);
    end

    // Stray evictDone in IDLE does nothing.
    evictDone = 1'b1;
    @(negedge clock);
    evictDone = 1'b0;
    chk("strayDone.evictRequest", evictRequest, 0);
    chk("strayDone.allocateGrant", allocateGrant, 0);

    // Cold allocations, then fill the cache, then evictions.
    alloc(3'd3, 1'b0);
    alloc(3'd3, 1'b0);
    for (int i = 0; i < 8; i++) alloc(3'(i), 1'b0);
    alloc(3'd5, 1'b1);   // snoop on victim while evicting
    alloc(3'd5, 1'b0);   // line 5 valid again -> evicts

    // Invalidate line 2, then snoop it in the same cycle as its GRANT.
    @(negedge clock);
    snoopInvalidateEnable = 1'b1;
    snoopInvalidateLine   = 3'd2;
    validM[2]             = 1'b0;
    @(negedge clock);
    snoopInvalidateEnable = 1'b0;
    chk("snoop2.invalidateEnable", invalidateEnable, 1);
    alloc(3'd2, 1'b1);
    alloc(3'd2, 1'b0);   // grant won the race -> line 2 valid -> evicts

    // Asynchronous reset in the middle of an eviction.
    @(negedge clock);
    allocateRequest      = 1'b1;
    replacementCacheLine = 3'd2;
    repeat (3) @(negedge clock);
    chk("preReset.evictRequest", evictRequest, 1);
    #2 reset = 1'b0;
    #1 checkAllZero("midReset");
    allocateRequest = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) validM[i] = 1'b0;
    alloc(3'd4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
